// File: rtl/pwm_output.sv
// PWM generator with an Avalon-MM duty register behind a fixed-latency waitrequest handshake.
// New duty values are staged in a shadow register and applied only at period boundaries.
//   state    | meaning
//   S_IDLE   | no write in progress, waitrequest high
//   S_WAIT   | write seen, counting WAIT_CYCLES stall cycles
//   S_ACCEPT | single cycle with waitrequest low, shadow load on address match
module pwm_output #(
  parameter logic [15:0] ADDR        = 16'hDEAD,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned MAX_DUTY    = 4095
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pwm_address,
  input  logic        pwm_write,
  input  logic [31:0] pwm_writedata,
  output logic        pwm_waitrequest,
  output logic        pwm_out,
  output logic        period_start,
  output logic [11:0] duty_active
);
  localparam logic [11:0] MAX_CNT   = 12'(MAX_DUTY);
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCEPT} state_t;

  state_t      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [11:0] cnt_q, cnt_d;
  logic [11:0] shadow_q, shadow_d;
  logic [11:0] duty_q, duty_d;
  logic        pwm_q, pwm_d;
  logic        ps_q, ps_d;
  logic        load_shadow;
  logic        at_max;
  logic [11:0] sat_duty;
  logic        unused_wdata_hi;

  assign unused_wdata_hi = ^pwm_writedata[31:16];

  // Write data is a signed 16-bit value, clamped into 0..MAX_DUTY.
  always_comb begin
    sat_duty = pwm_writedata[11:0];
    if (pwm_writedata[15]) begin
      sat_duty = '0;
    end else if (pwm_writedata[14:0] > 15'(MAX_DUTY)) begin
      sat_duty = MAX_CNT;
    end
  end

  always_comb begin
    state_d         = state_q;
    wait_cnt_d      = wait_cnt_q;
    pwm_waitrequest = 1'b1;
    load_shadow     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pwm_write) begin
          state_d    = S_WAIT;
          wait_cnt_d = WAIT_LOAD;
        end
      end
      S_WAIT: begin
        if (!pwm_write) begin
          state_d = S_IDLE;
        end else if (wait_cnt_q == 4'd0) begin
          state_d = S_ACCEPT;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      S_ACCEPT: begin
        pwm_waitrequest = 1'b0;
        load_shadow     = (pwm_address == ADDR);
        state_d         = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign at_max = (cnt_q == MAX_CNT);

  // duty_q samples the pre-edge shadow, so a capture on the wrap cycle waits one more period.
  always_comb begin
    cnt_d    = at_max ? 12'd0 : cnt_q + 12'd1;
    shadow_d = load_shadow ? sat_duty : shadow_q;
    duty_d   = at_max ? shadow_q : duty_q;
    pwm_d    = (cnt_q < duty_q);
    ps_d     = at_max;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      cnt_q      <= '0;
      shadow_q   <= '0;
      duty_q     <= '0;
      pwm_q      <= 1'b0;
      ps_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
      duty_q     <= duty_d;
      pwm_q      <= pwm_d;
      ps_q       <= ps_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = ps_q;
  assign duty_active  = duty_q;

endmodule

// File: tb/tb_pwm_output.sv
// Self-checking bench for pwm_output: handshake timing, saturation, boundary loading and reset abort.
`timescale 1ns/1ps
module tb_pwm_output;
  localparam logic [15:0] ADDR        = 16'hDEAD;
  localparam int          WAIT_CYCLES = 2;
  localparam int          MAX_DUTY    = 4095;
  localparam int          PERIOD      = MAX_DUTY + 1;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    int          exp_duty;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] pwm_address = '0;
  logic        pwm_write = 1'b0;
  logic [31:0] pwm_writedata = '0;
  logic        pwm_waitrequest;
  logic        pwm_out;
  logic        period_start;
  logic [11:0] duty_active;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];
  bit wr_q[$];
  vec_t vecs[6];

  int acc_hi, acc_len, last_hi, last_len;

  pwm_output #(.ADDR(ADDR), .WAIT_CYCLES(WAIT_CYCLES), .MAX_DUTY(MAX_DUTY)) dut (
    .clk             (clk),
    .reset           (reset),
    .pwm_address     (pwm_address),
    .pwm_write       (pwm_write),
    .pwm_writedata   (pwm_writedata),
    .pwm_waitrequest (pwm_waitrequest),
    .pwm_out         (pwm_out),
    .period_start    (period_start),
    .duty_active     (duty_active)
  );

  always #5 clk = ~clk;

  // High-cycle count and length of each period, measured between period_start pulses.
  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      acc_hi   <= 0;
      acc_len  <= 0;
      last_hi  <= 0;
      last_len <= 0;
    end else if (period_start) begin
      last_hi  <= acc_hi;
      last_len <= acc_len;
      acc_hi   <= pwm_out ? 1 : 0;
      acc_len  <= 1;
    end else begin
      acc_hi   <= acc_hi + (pwm_out ? 1 : 0);
      acc_len  <= acc_len + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_ps(input int budget, output int waited);
    bit seen;
    seen   = 1'b0;
    waited = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      waited++;
      if (period_start === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    #1;
    check("period_start_seen", 32'(seen), 32'd1);
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [31:0] data);
    @(posedge clk);
    #1;
    pwm_address   = addr;
    pwm_writedata = data;
    pwm_write     = 1'b1;
    for (int i = 0; i <= WAIT_CYCLES; i++) wr_q.push_back(1'b1);
    wr_q.push_back(1'b0);
    while (wr_q.size() > 0) begin
      @(negedge clk);
      check("waitrequest", 32'(pwm_waitrequest), 32'(wr_q.pop_front()));
    end
    @(posedge clk);
    #1;
    pwm_write = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    int prev_exp;

    vecs[0] = '{ADDR,     32'hFFFF_FFEC, 0};
    vecs[1] = '{ADDR,     32'd5000,      4095};
    vecs[2] = '{16'hBEEF, 32'd200,       4095};
    vecs[3] = '{ADDR,     32'hABCD_8000, 0};
    vecs[4] = '{ADDR,     32'h1234_0FFF, 4095};
    vecs[5] = '{ADDR,     32'd1,         1};

    // reset values
    repeat (3) @(negedge clk);
    check("rst_waitrequest", 32'(pwm_waitrequest), 32'd1);
    check("rst_pwm_out", 32'(pwm_out), 32'd0);
    check("rst_period_start", 32'(period_start), 32'd0);
    check("rst_duty", 32'(duty_active), 32'd0);
    #1 reset = 1'b1;
    wait_ps(PERIOD + 16, waited);
    check("first_period_len", 32'(waited), 32'(PERIOD));

    // basic write, applied at next wrap
    exp_q.push_back(1000);
    bus_write(ADDR, 32'd1000);
    wait_ps(PERIOD + 16, waited);
    check("duty_after_1000", 32'(duty_active), 32'(exp_q.pop_front()));

    // other address completes handshake, aborted write never reaches ACCEPT
    bus_write(16'hBEEF, 32'd200);
    @(posedge clk);
    #1;
    pwm_address   = ADDR;
    pwm_writedata = 32'd3000;
    pwm_write     = 1'b1;
    repeat (6) wr_q.push_back(1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_waitrequest", 32'(pwm_waitrequest), 32'(wr_q.pop_front()));
      if (i == 1) begin
        @(posedge clk);
        #1;
        pwm_write = 1'b0;
      end
    end
    exp_q.push_back(1000);
    wait_ps(PERIOD + 16, waited);
    check("duty_unchanged_1000", 32'(duty_active), 32'(exp_q.pop_front()));
    check("highs_1000", 32'(last_hi), 32'd1000);
    check("period_len_1000", 32'(last_len), 32'(PERIOD));

    // capture on the wrap cycle applies one period late
    exp_q.push_back(100);
    bus_write(ADDR, 32'd100);
    wait_ps(PERIOD + 16, waited);
    check("duty_100", 32'(duty_active), 32'(exp_q.pop_front()));
    repeat (PERIOD - 5) @(posedge clk);
    exp_q.push_back(100);
    exp_q.push_back(300);
    bus_write(ADDR, 32'd300);
    wait_ps(PERIOD + 16, waited);
    check("accept_on_wrap", 32'(waited), 32'd1);
    check("boundary_old_shadow", 32'(duty_active), 32'(exp_q.pop_front()));
    wait_ps(PERIOD + 16, waited);
    check("boundary_new_shadow", 32'(duty_active), 32'(exp_q.pop_front()));

    // reset asserted mid-WAIT
    @(posedge clk);
    #1;
    pwm_address   = ADDR;
    pwm_writedata = 32'd2000;
    pwm_write     = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("pre_rst_waitrequest", 32'(pwm_waitrequest), 32'd1);
    check("pre_rst_pwm_out", 32'(pwm_out), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_waitrequest", 32'(pwm_waitrequest), 32'd1);
    check("mid_rst_pwm_out", 32'(pwm_out), 32'd0);
    check("mid_rst_duty", 32'(duty_active), 32'd0);
    pwm_write = 1'b0;
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    exp_q.push_back(2048);
    bus_write(ADDR, 32'd2048);
    wait_ps(PERIOD + 16, waited);
    check("post_rst_duty", 32'(duty_active), 32'(exp_q.pop_front()));
    exp_q.push_back(2048);
    wait_ps(PERIOD + 16, waited);
    check("duty_2048_held", 32'(duty_active), 32'(exp_q.pop_front()));
    check("highs_2048", 32'(last_hi), 32'd2048);
    check("period_len_2048", 32'(last_len), 32'(PERIOD));

    // table: each write lands during one period and is measured over the next
    prev_exp = 2048;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(vecs[i].exp_duty);
      bus_write(vecs[i].addr, vecs[i].data);
      wait_ps(PERIOD + 16, waited);
      check($sformatf("vec%0d_duty", i), 32'(duty_active), 32'(exp_q.pop_front()));
      check($sformatf("vec%0d_prev_highs", i), 32'(last_hi), 32'(prev_exp));
      check($sformatf("vec%0d_period_len", i), 32'(last_len), 32'(PERIOD));
      prev_exp = vecs[i].exp_duty;
    end
    wait_ps(PERIOD + 16, waited);
    check("last_vec_highs", 32'(last_hi), 32'(prev_exp));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pwm_output.md
PWM_OUTPUT -- requirements
Module: pwm_output

Interface
REQ-001 SHALL provide parameter ADDR, default 16'hDEAD: the only address whose writes update the duty.
REQ-002 SHALL provide parameter WAIT_CYCLES, default 2: the number of waitrequest-high cycles inserted before a write is accepted, legal range 1..15.
REQ-003 SHALL provide parameter MAX_DUTY, default 4095: the saturation ceiling and the last counter value of the period.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port pwm_address, input, 16, Avalon-MM slave address.
REQ-007 SHALL have port pwm_write, input, 1, Avalon-MM write request.
REQ-008 SHALL have port pwm_writedata, input, 32, write data; only bits [15:0] are used, as a signed value.
REQ-009 SHALL have port pwm_waitrequest, output, 1, Avalon-MM waitrequest.
REQ-010 SHALL have port pwm_out, output, 1, registered PWM output.
REQ-011 SHALL have port period_start, output, 1, one-cycle pulse marking counter value 0.
REQ-012 SHALL have port duty_active, output, 12, the duty value currently applied.

Function
REQ-013 Write FSM SHALL have states IDLE, WAIT and ACCEPT; pwm_waitrequest is 1 in IDLE and WAIT and 0 only in ACCEPT.
- IDLE -> WAIT when pwm_write=1.
REQ-014 WAIT SHALL count WAIT_CYCLES cycles, then go to ACCEPT; if pwm_write drops during WAIT, it SHALL return to IDLE with no capture.
REQ-015 ACCEPT SHALL last exactly one cycle, then go to IDLE, so back-to-back writes each take WAIT_CYCLES+2 cycles.
- In ACCEPT, if pwm_address==ADDR, the block SHALL load the shadow duty register.
REQ-016 A write to any other address SHALL still complete the handshake (no bus hang) but SHALL be discarded.
REQ-017 Saturation SHALL be applied to signed pwm_writedata[15:0] when loading shadow:
- value < 0 -> 0
- value > MAX_DUTY -> MAX_DUTY
- otherwise the value unchanged
REQ-018 A free-running 12-bit counter SHALL count 0..MAX_DUTY and then wrap to 0, giving a period of MAX_DUTY+1 cycles.
REQ-019 When counter==MAX_DUTY, duty_active SHALL load shadow on the next edge, so a new duty takes effect at a period boundary only.
REQ-020 If an ACCEPT capture and counter==MAX_DUTY occur in the same cycle, duty_active SHALL take the old shadow value; the new value applies from the following period.
REQ-021 pwm_out SHALL be registered as (counter < duty_active), one cycle after the counter value.
- duty 0 -> pwm_out constantly 0.
- duty MAX_DUTY -> pwm_out high MAX_DUTY cycles per period.
REQ-022 period_start SHALL be registered as (counter==MAX_DUTY), so it is high exactly in the cycle the counter reads 0.
REQ-023 Counter and duty logic SHALL be independent of bus activity; writes never stall or restart the counter.

Reset
REQ-024 While reset=0, regardless of clk, the block SHALL hold these values:
- FSM = IDLE
- pwm_waitrequest = 1
- counter = 0, shadow = 0, duty_active = 0
- pwm_out = 0, period_start = 0
REQ-025 Reset asserted mid-handshake SHALL abort it with no capture.
- After release, the FSM starts in IDLE.
- The counter restarts from 0 on the first edge after release.

Verification
REQ-026 Handshake latency: write addr 16'hDEAD data 1000 with WAIT_CYCLES=2 -> pwm_waitrequest low exactly in the 4th cycle after pwm_write rises, and duty_active = 1000 after the next wrap.
REQ-027 Saturation, checked via duty_active after a wrap:
- write -20 (32'hFFFFFFEC) -> duty_active = 0 and pwm_out constantly 0.
- write 5000 -> duty_active = 4095 and pwm_out high 4095 of 4096 cycles.
REQ-028 Other address and abort cases leave duty_active unchanged at 1000:
- write 16'hBEEF data 200 -> handshake completes.
- pwm_write dropped in WAIT -> no ACCEPT cycle.
REQ-029 Boundary write: ACCEPT with data 300 coinciding with counter==4095 while shadow=100 -> next period duty_active=100, the period after 300.
REQ-030 Duty check: with duty 2048, pwm_out counts exactly 2048 high cycles between consecutive period_start pulses.
- period_start spacing is 4096 cycles.
REQ-031 Reset mid-WAIT: reset=0 mid-WAIT -> pwm_waitrequest=1 and pwm_out=0 immediately, with no capture.
- After release, a normal write succeeds.
